// File: rtl/fft_pkg.sv
// Shared FFT types: wide complex sample, stage phase and the trivial -j twiddle.
package fft_pkg;

  // Wide enough for any stage width in the pipeline; stages slice the low bits they need.
  localparam int unsigned CplxW = 32;

  typedef logic signed [CplxW-1:0] samp_t;

  typedef struct packed {
    samp_t re;
    samp_t im;
  } cplx_t;

  typedef enum logic {
    StFill,
    StComb
  } phase_e;

  // Multiply by -j: (re + j*im) * -j = im - j*re.
  function automatic cplx_t rot_mj(input cplx_t x);
    cplx_t r;
    r.re = x.im;
    r.im = -x.re;
    return r;
  endfunction

endpackage

// File: rtl/bfly_delay_buf.sv
// Half-frame delay buffer: one block of Lanes complex samples per slot.
module bfly_delay_buf #(
  parameter int unsigned Lanes = 16,
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [AddrW-1:0]             wr_addr_i,
  input  logic [Lanes-1:0][Width-1:0]  wr_re_i,
  input  logic [Lanes-1:0][Width-1:0]  wr_im_i,
  input  logic [AddrW-1:0]             rd_addr_i,
  output logic [Lanes-1:0][Width-1:0]  rd_re_o,
  output logic [Lanes-1:0][Width-1:0]  rd_im_o
);

  logic [Depth-1:0][Lanes-1:0][Width-1:0] mem_re_q, mem_re_d;
  logic [Depth-1:0][Lanes-1:0][Width-1:0] mem_im_q, mem_im_d;

  // Write the addressed slot when enabled.
  always_comb begin
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;
    if (wr_en_i) begin
      mem_re_d[wr_addr_i] = wr_re_i;
      mem_im_d[wr_addr_i] = wr_im_i;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_re_q <= '0;
      mem_im_q <= '0;
    end else begin
      mem_re_q <= mem_re_d;
      mem_im_q <= mem_im_d;
    end
  end

  assign rd_re_o = mem_re_q[rd_addr_i];
  assign rd_im_o = mem_im_q[rd_addr_i];

endmodule

// File: rtl/bfly_r2_stream_stage.sv
// Streaming radix-2 DIF butterfly stage: buffers the first half-frame, then emits
// sum/difference blocks one per cycle, with an optional -j on the upper quarter.
module bfly_r2_stream_stage
  import fft_pkg::*;
#(
  parameter int unsigned LANES  = 16,
  parameter int unsigned WIN    = 9,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ROT_EN = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_valid,
  input  logic signed [LANES-1:0][WIN-1:0]     din_re,
  input  logic signed [LANES-1:0][WIN-1:0]     din_im,
  output logic                                 dout_valid,
  output logic [$clog2(DEPTH)-1:0]             dout_blk,
  output logic                                 dout_last,
  output logic signed [LANES-1:0][WIN:0]       dout_p_re,
  output logic signed [LANES-1:0][WIN:0]       dout_p_im,
  output logic signed [LANES-1:0][WIN:0]       dout_n_re,
  output logic signed [LANES-1:0][WIN:0]       dout_n_im
);

  localparam int unsigned OW   = WIN + 1;
  localparam int unsigned CntW = $clog2(DEPTH);

  typedef logic [LANES-1:0][OW-1:0] vec_t;

  phase_e            phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   blk_q, blk_d;
  logic              last_q, last_d;
  vec_t              p_re_q, p_re_d, p_im_q, p_im_d;
  vec_t              n_re_q, n_re_d, n_im_q, n_im_d;
  vec_t              p_re_c, p_im_c, n_re_c, n_im_c;

  logic                        wr_en;
  logic                        cnt_max;
  logic                        rot_sel;
  logic                        unused_hi;
  logic [LANES-1:0][WIN-1:0]   a_re, a_im;

  bfly_delay_buf #(
    .Lanes (LANES),
    .Width (WIN),
    .Depth (DEPTH),
    .AddrW (CntW)
  ) u_delay_buf (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q),
    .wr_re_i   (din_re),
    .wr_im_i   (din_im),
    .rd_addr_i (cnt_q),
    .rd_re_o   (a_re),
    .rd_im_o   (a_im)
  );

  assign cnt_max = (cnt_q == CntW'(DEPTH - 1));
  // Upper half of the combine index range is the upper quarter of the frame.
  assign rot_sel = (ROT_EN != 0) && cnt_q[CntW-1];

  // Butterfly datapath: sign-extend, add/sub, optional -j on the difference.
  always_comb begin
    p_re_c    = '0;
    p_im_c    = '0;
    n_re_c    = '0;
    n_im_c    = '0;
    unused_hi = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      logic signed [OW-1:0] ar, ai, br, bi, dr, di;
      cplx_t d, n;
      ar = OW'($signed(a_re[i]));
      ai = OW'($signed(a_im[i]));
      br = OW'($signed(din_re[i]));
      bi = OW'($signed(din_im[i]));
      p_re_c[i] = ar + br;
      p_im_c[i] = ai + bi;
      dr = ar - br;
      di = ai - bi;
      d.re = CplxW'(dr);
      d.im = CplxW'(di);
      n = rot_sel ? rot_mj(d) : d;
      n_re_c[i] = n.re[OW-1:0];
      n_im_c[i] = n.im[OW-1:0];
      unused_hi = unused_hi ^ (^{n.re[CplxW-1:OW], n.im[CplxW-1:OW]});
    end
  end

  // Counter/phase FSM and output next-state; idle cycles change nothing but valid/last.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    blk_d   = blk_q;
    p_re_d  = p_re_q;
    p_im_d  = p_im_q;
    n_re_d  = n_re_q;
    n_im_d  = n_im_q;
    if (din_valid) begin
      cnt_d = cnt_max ? '0 : cnt_q + CntW'(1);
      unique case (phase_q)
        StFill: begin
          wr_en = 1'b1;
          if (cnt_max) phase_d = StComb;
        end
        StComb: begin
          valid_d = 1'b1;
          blk_d   = cnt_q;
          last_d  = cnt_max;
          p_re_d  = p_re_c;
          p_im_d  = p_im_c;
          n_re_d  = n_re_c;
          n_im_d  = n_im_c;
          if (cnt_max) phase_d = StFill;
        end
        default: phase_d = StFill;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= StFill;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      p_re_q  <= '0;
      p_im_q  <= '0;
      n_re_q  <= '0;
      n_im_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
      n_re_q  <= n_re_d;
      n_im_q  <= n_im_d;
    end
  end

  assign dout_valid = valid_q;
  assign dout_blk   = blk_q;
  assign dout_last  = last_q;
  assign dout_p_re  = p_re_q;
  assign dout_p_im  = p_im_q;
  assign dout_n_re  = n_re_q;
  assign dout_n_im  = n_im_q;

endmodule

// File: tb/tb_bfly_r2_stream_stage.sv
// Scoreboard bench: a frame-level model queues expected blocks, a monitor checks them.
module tb_bfly_r2_stream_stage;

  localparam int LANES = 16;
  localparam int WIN   = 9;
  localparam int DEPTH = 16;
  localparam int OW    = WIN + 1;
  localparam int BW    = $clog2(DEPTH);

  typedef logic [LANES-1:0][OW-1:0] vec_t;

  typedef struct {
    int   blk;
    bit   last;
    int   due;
    vec_t p_re, p_im, n_re, n_im, n0_re, n0_im;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      din_valid;
  logic [LANES-1:0][WIN-1:0] din_re, din_im;

  logic          dout_valid, dout_last, dout0_valid, dout0_last;
  logic [BW-1:0] dout_blk, dout0_blk;
  vec_t          dout_p_re, dout_p_im, dout_n_re, dout_n_im;
  vec_t          dout0_p_re, dout0_p_im, dout0_n_re, dout0_n_im;

  bfly_r2_stream_stage #(
    .LANES(LANES), .WIN(WIN), .DEPTH(DEPTH), .ROT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_blk(dout_blk), .dout_last(dout_last),
    .dout_p_re(dout_p_re), .dout_p_im(dout_p_im), .dout_n_re(dout_n_re), .dout_n_im(dout_n_im)
  );

  bfly_r2_stream_stage #(
    .LANES(LANES), .WIN(WIN), .DEPTH(DEPTH), .ROT_EN(0)
  ) dut0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(dout0_valid), .dout_blk(dout0_blk), .dout_last(dout0_last),
    .dout_p_re(dout0_p_re), .dout_p_im(dout0_p_im),
    .dout_n_re(dout0_n_re), .dout_n_im(dout0_n_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t expq[$];
  exp_t last_e;
  int   checks = 0;
  int   passed = 0;
  int   cur_re[LANES], cur_im[LANES];
  int   st_re[DEPTH][LANES], st_im[DEPTH][LANES];
  int   k = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic clear_last();
    last_e.p_re = '0; last_e.p_im = '0; last_e.n_re = '0; last_e.n_im = '0;
    last_e.n0_re = '0; last_e.n0_im = '0;
  endtask

  // Frame model: position k in the 2*DEPTH frame; second half pairs with stored first half.
  task automatic model_push();
    exp_t e;
    int j, p, pi, dr, di, nr, ni, mdr;
    if (k < DEPTH) begin
      for (int l = 0; l < LANES; l++) begin
        st_re[k][l] = cur_re[l];
        st_im[k][l] = cur_im[l];
      end
    end else begin
      j      = k - DEPTH;
      e.blk  = j;
      e.last = (j == DEPTH - 1);
      e.due  = cyc + 1;
      for (int l = 0; l < LANES; l++) begin
        p   = st_re[j][l] + cur_re[l];
        pi  = st_im[j][l] + cur_im[l];
        dr  = st_re[j][l] - cur_re[l];
        di  = st_im[j][l] - cur_im[l];
        mdr = -dr;
        if (j >= DEPTH / 2) begin nr = di; ni = mdr; end
        else begin nr = dr; ni = di; end
        e.p_re[l]  = p[OW-1:0];
        e.p_im[l]  = pi[OW-1:0];
        e.n_re[l]  = nr[OW-1:0];
        e.n_im[l]  = ni[OW-1:0];
        e.n0_re[l] = dr[OW-1:0];
        e.n0_im[l] = di[OW-1:0];
      end
      expq.push_back(e);
    end
    k = (k + 1) % (2 * DEPTH);
  endtask

  task automatic fill(input int re, input int im);
    for (int l = 0; l < LANES; l++) begin cur_re[l] = re; cur_im[l] = im; end
  endtask

  task automatic rand_blk();
    for (int l = 0; l < LANES; l++) begin
      cur_re[l] = int'($urandom_range(511, 0)) - 256;
      cur_im[l] = int'($urandom_range(511, 0)) - 256;
    end
  endtask

  // Called at posedge+1; presents one block and moves to the next posedge+1.
  task automatic drive(input bit v);
    din_valid = v;
    for (int l = 0; l < LANES; l++) begin
      din_re[l] = cur_re[l][WIN-1:0];
      din_im[l] = cur_im[l][WIN-1:0];
    end
    if (v) model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero();
    chk("rst_valid", dout_valid, 0);
    chk("rst_blk", dout_blk, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_p_re", dout_p_re, 0);
    chk("rst_p_im", dout_p_im, 0);
    chk("rst_n_re", dout_n_re, 0);
    chk("rst_n_im", dout_n_im, 0);
    chk("rst_norot_valid", dout0_valid, 0);
  endtask

  task automatic reset_mid();
    #2;
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    chk_zero();
    expq.delete();
    k = 0;
    clear_last();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: pop on every valid output; otherwise outputs must hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dout_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_valid", dout_valid, 0);
      end else begin
        e = expq.pop_front();
        chk("latency", cyc, e.due);
        chk("blk", dout_blk, e.blk);
        chk("last", dout_last, e.last);
        chk("p_re", dout_p_re, e.p_re);
        chk("p_im", dout_p_im, e.p_im);
        chk("n_re", dout_n_re, e.n_re);
        chk("n_im", dout_n_im, e.n_im);
        chk("norot_valid", dout0_valid, 1);
        chk("norot_n_re", dout0_n_re, e.n0_re);
        chk("norot_n_im", dout0_n_im, e.n0_im);
        last_e = e;
      end
    end else begin
      chk("idle_last", dout_last, 0);
      chk("idle_norot_valid", dout0_valid, 0);
      chk("hold_p_re", dout_p_re, last_e.p_re);
      chk("hold_p_im", dout_p_im, last_e.p_im);
      chk("hold_n_re", dout_n_re, last_e.n_re);
      chk("hold_n_im", dout_n_im, last_e.n_im);
    end
  end

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din_re    = '0;
    din_im    = '0;
    clear_last();
    fill(0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic frame
    repeat (DEPTH) begin fill(10, 0); drive(1); end
    repeat (DEPTH) begin fill(3, 0); drive(1); end
    // Extremes: max-magnitude difference, then most negative sum
    repeat (DEPTH) begin fill(-256, -256); drive(1); end
    repeat (DEPTH) begin fill(255, 255); drive(1); end
    repeat (DEPTH) begin fill(-256, -256); drive(1); end
    repeat (DEPTH) begin fill(-256, -256); drive(1); end
    // Basic frame with a gap after every valid block
    for (int i = 0; i < 2 * DEPTH; i++) begin
      fill((i < DEPTH) ? 10 : 3, 0);
      drive(1);
      rand_blk();
      drive(0);
    end
    // Two back-to-back random frames
    repeat (4 * DEPTH) begin rand_blk(); drive(1); end
    // Reset in the middle of a combine half, then a fresh frame
    repeat (DEPTH + 4) begin rand_blk(); drive(1); end
    reset_mid();
    repeat (2 * DEPTH) begin rand_blk(); drive(1); end
    // Random frames with random gaps
    for (int n = 0; n < 4 * DEPTH;) begin
      rand_blk();
      if ($urandom_range(2, 0) != 0) begin drive(1); n++; end
      else drive(0);
    end
    // Drain and confirm nothing is left outstanding
    repeat (4) drive(0);
    chk("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
